// File: rtl/mcc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
// Opcode/funct constants, mux select codes and the legality check.
package mcc_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;

   localparam logic [2:0] PCSRC_ALU    = 3'b000;
   localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
   localparam logic [2:0] PCSRC_JUMP   = 3'b010;
   localparam logic [2:0] PCSRC_RS     = 3'b011;
   localparam logic [2:0] PCSRC_EXC    = 3'b100;

   localparam logic [1:0] REGDST_RT = 2'b00;
   localparam logic [1:0] REGDST_RD = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;
   localparam logic [1:0] REGDST_K0 = 2'b11;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   localparam logic [1:0] AS2_REG   = 2'b00;
   localparam logic [1:0] AS2_FOUR  = 2'b01;
   localparam logic [1:0] AS2_IMM   = 2'b10;
   localparam logic [1:0] AS2_IMMSH = 2'b11;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_SUB    = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
   localparam logic [1:0] ALUOP_OPCODE = 2'b11;

   typedef struct packed {
      logic       IRWrite;
      logic       PCWrite;
      logic       PCWriteCond;
      logic       RegWrite;
      logic       MemRead;
      logic       MemWrite;
      logic       ALUSrc1;
      logic       ExtOp;
      logic       LuOp;
      logic [2:0] PCSrc;
      logic [1:0] RegDst;
      logic [1:0] MemToReg;
      logic [1:0] ALUSrc2;
      logic [1:0] ALUOp;
      logic       trap;
   } ctrl_t;

   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
      if (op == OP_RTYPE)
         return funct inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2a, 6'h2b};
      return (op inside {[6'h01:6'h0f]}) || (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-field, interrupt, memory-handshake and datapath-control bundle
// between the control FSM (master) and the multicycle datapath (slave).
interface multicycle_controller_if #(parameter int IRQ_LINES = 4);
   localparam int CW = $clog2(IRQ_LINES + 1);

   logic [5:0]           OpCode;
   logic [5:0]           Funct;
   logic [IRQ_LINES-1:0] irq_req;
   logic [IRQ_LINES-1:0] irq_mask;
   logic                 pc_kernel;
   logic                 mem_ready;

   logic IRWrite, PCWrite, PCWriteCond, RegWrite, MemRead, MemWrite;
   logic ALUSrc1, ExtOp, LuOp;
   logic [2:0]    PCSrc;
   logic [1:0]    RegDst, MemToReg, ALUSrc2, ALUOp;
   logic          trap;
   logic [CW-1:0] cause;

   modport master (
      input  OpCode, Funct, irq_req, irq_mask, pc_kernel, mem_ready,
      output IRWrite, PCWrite, PCWriteCond, RegWrite, MemRead, MemWrite,
             ALUSrc1, ExtOp, LuOp, PCSrc, RegDst, MemToReg, ALUSrc2, ALUOp,
             trap, cause
   );

   modport slave (
      output OpCode, Funct, irq_req, irq_mask, pc_kernel, mem_ready,
      input  IRWrite, PCWrite, PCWriteCond, RegWrite, MemRead, MemWrite,
             ALUSrc1, ExtOp, LuOp, PCSrc, RegDst, MemToReg, ALUSrc2, ALUOp,
             trap, cause
   );
endinterface

// File: rtl/multicycle_controller_irq_arbiter.sv
// Pending-interrupt latch with mask gating and lowest-index priority.
// Causes are 1-based line numbers; a take strobe clears the named line.
module irq_arbiter #(
   parameter int IRQ_LINES = 4,
   parameter int CW        = $clog2(IRQ_LINES + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IRQ_LINES-1:0] irqReq,
   input  logic [IRQ_LINES-1:0] irqMask,
   input  logic                 take,
   input  logic [CW-1:0]        takeCause,
   output logic                 anyPending,
   output logic [CW-1:0]        selCause
);
   logic [IRQ_LINES-1:0] pendingReg, pendingNext, clearVec, takeable;

   generate
      for (genvar gi = 0; gi < IRQ_LINES; gi++) begin : g_clear
         assign clearVec[gi] = take && (takeCause == CW'(gi + 1));
      end
   endgenerate

   // Clearing beats a same-cycle request; the line re-latches next cycle.
   assign pendingNext = (pendingReg | (irqReq & irqMask)) & ~clearVec;
   assign takeable    = pendingReg & irqMask;
   assign anyPending  = |takeable;

   always_comb begin
      selCause = '0;
      for (int i = IRQ_LINES - 1; i >= 0; i--) begin
         if (takeable[i]) selCause = CW'(i + 1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pendingReg <= '0;
      else        pendingReg <= pendingNext;
   end
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with memory stalls,
// illegal-instruction trapping and maskable interrupts taken at fetch entry.
module multicycle_controller
   import mcc_pkg::*;
#(
   parameter int IRQ_LINES = 4
) (
   input logic clk,
   input logic reset,
   multicycle_controller_if.master bus
);
   localparam int CW = $clog2(IRQ_LINES + 1);

   state_t        stateReg, stateNext;
   logic          fetchBusyReg, fetchBusyNext;
   logic [CW-1:0] causeReg, causeNext, selCause;
   logic          anyPending, trapTake, legal, isShift;
   ctrl_t         ctl, ctlOut;

   irq_arbiter #(.IRQ_LINES(IRQ_LINES), .CW(CW)) u_arb (
      .clk        (clk),
      .reset      (reset),
      .irqReq     (bus.irq_req),
      .irqMask    (bus.irq_mask),
      .take       (stateReg == TRAP && causeReg != '0),
      .takeCause  (causeReg),
      .anyPending (anyPending),
      .selCause   (selCause)
   );

   // Interrupts are considered only on the first cycle of a fetch.
   assign trapTake = (stateReg == FETCH) && !fetchBusyReg && anyPending && !bus.pc_kernel;
   assign legal    = is_legal(bus.OpCode, bus.Funct);
   assign isShift  = bus.Funct inside {FN_SLL, FN_SRL, FN_SRA};

   always_comb begin
      fetchBusyNext = (stateReg == FETCH) && !trapTake && !bus.mem_ready;
      causeNext     = causeReg;
      if (trapTake)                         causeNext = selCause;
      else if (stateReg == DECODE && !legal) causeNext = '0;
   end

   always_comb begin
      stateNext = stateReg;
      ctl       = '0;
      case (stateReg)
         FETCH: begin
            if (trapTake) begin
               stateNext = TRAP;
            end else begin
               ctl.MemRead = 1'b1;
               ctl.ALUSrc2 = AS2_FOUR;
               if (bus.mem_ready) begin
                  ctl.IRWrite = 1'b1;
                  ctl.PCWrite = 1'b1;
                  ctl.PCSrc   = PCSRC_ALU;
                  stateNext   = DECODE;
               end
            end
         end
         DECODE: begin
            ctl.ALUSrc2 = AS2_IMMSH;
            stateNext   = EXEC;
            if (!legal) begin
               stateNext = TRAP;
            end else if (bus.OpCode == OP_J || bus.OpCode == OP_JAL) begin
               ctl.PCWrite = 1'b1;
               ctl.PCSrc   = PCSRC_JUMP;
               if (bus.OpCode == OP_JAL) begin
                  ctl.RegWrite = 1'b1;
                  ctl.RegDst   = REGDST_RA;
                  ctl.MemToReg = M2R_PC;
               end
               stateNext = FETCH;
            end else if (bus.OpCode == OP_RTYPE && (bus.Funct == FN_JR || bus.Funct == FN_JALR)) begin
               ctl.PCWrite = 1'b1;
               ctl.PCSrc   = PCSRC_RS;
               if (bus.Funct == FN_JALR) begin
                  ctl.RegWrite = 1'b1;
                  ctl.RegDst   = REGDST_RD;
                  ctl.MemToReg = M2R_PC;
               end
               stateNext = FETCH;
            end
         end
         EXEC: begin
            if (bus.OpCode == OP_RTYPE) begin
               ctl.ALUOp   = ALUOP_FUNCT;
               ctl.ALUSrc1 = isShift;
               stateNext   = WB;
            end else if (bus.OpCode inside {[6'h08:6'h0f]}) begin
               ctl.ALUSrc2 = AS2_IMM;
               ctl.ALUOp   = ALUOP_OPCODE;
               ctl.ExtOp   = !(bus.OpCode inside {OP_ADDIU, OP_SLTIU, OP_ANDI});
               ctl.LuOp    = (bus.OpCode == OP_LUI);
               stateNext   = WB;
            end else if (bus.OpCode == OP_LW || bus.OpCode == OP_SW) begin
               ctl.ALUSrc2 = AS2_IMM;
               ctl.ALUOp   = ALUOP_ADD;
               stateNext   = MEM;
            end else begin
               ctl.ALUOp       = ALUOP_SUB;
               ctl.PCWriteCond = 1'b1;
               ctl.PCSrc       = PCSRC_ALUOUT;
               stateNext       = FETCH;
            end
         end
         MEM: begin
            ctl.MemRead  = (bus.OpCode == OP_LW);
            ctl.MemWrite = (bus.OpCode != OP_LW);
            if (bus.mem_ready) stateNext = (bus.OpCode == OP_LW) ? WB : FETCH;
         end
         WB: begin
            ctl.RegWrite = 1'b1;
            ctl.RegDst   = (bus.OpCode == OP_RTYPE) ? REGDST_RD : REGDST_RT;
            ctl.MemToReg = (bus.OpCode == OP_LW) ? M2R_MDR : M2R_ALUOUT;
            stateNext    = FETCH;
         end
         TRAP: begin
            ctl.RegWrite = 1'b1;
            ctl.RegDst   = REGDST_K0;
            ctl.MemToReg = M2R_PC;
            ctl.PCWrite  = 1'b1;
            ctl.PCSrc    = PCSRC_EXC;
            ctl.trap     = 1'b1;
            stateNext    = FETCH;
         end
         default: stateNext = FETCH;
      endcase
   end

   // Held reset silences every control immediately, aborting any memory write.
   assign ctlOut          = reset ? ctl : '0;
   assign bus.IRWrite     = ctlOut.IRWrite;
   assign bus.PCWrite     = ctlOut.PCWrite;
   assign bus.PCWriteCond = ctlOut.PCWriteCond;
   assign bus.RegWrite    = ctlOut.RegWrite;
   assign bus.MemRead     = ctlOut.MemRead;
   assign bus.MemWrite    = ctlOut.MemWrite;
   assign bus.ALUSrc1     = ctlOut.ALUSrc1;
   assign bus.ExtOp       = ctlOut.ExtOp;
   assign bus.LuOp        = ctlOut.LuOp;
   assign bus.PCSrc       = ctlOut.PCSrc;
   assign bus.RegDst      = ctlOut.RegDst;
   assign bus.MemToReg    = ctlOut.MemToReg;
   assign bus.ALUSrc2     = ctlOut.ALUSrc2;
   assign bus.ALUOp       = ctlOut.ALUOp;
   assign bus.trap        = ctlOut.trap;
   assign bus.cause       = ctlOut.trap ? causeReg : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateReg     <= FETCH;
         fetchBusyReg <= 1'b0;
         causeReg     <= '0;
      end else begin
         stateReg     <= stateNext;
         fetchBusyReg <= fetchBusyNext;
         causeReg     <= causeNext;
      end
   end
endmodule
